// File: rtl/generable_mem_sweep_pkg.sv
// Shared definitions for the sweep-cleared, lane-enabled memory: state encoding,
// lane slicing helper and the lane/width compatibility check.
package generable_mem_sweep_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SWEEP = ST_SWEEP
  } state_e;

  // LSB position of lane 'lane' inside a word made of mem_w-bit lanes.
  function automatic int lane_lsb(input int lane, input int mem_w);
    return mem_w * lane;
  endfunction

  function automatic bit lanes_ok(input int data_w, input int mem_w);
    return (mem_w > 0) && (data_w >= mem_w) && ((data_w % mem_w) == 0);
  endfunction

endpackage

// File: rtl/generable_mem_lane.sv
// One MEM_W-bit lane of the memory: plain write port and an enabled, registered
// read port so the array maps onto block RAM.
module generable_mem_lane #(
  parameter int ADDR_W = 10,
  parameter int MEM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [MEM_W-1:0]  wdata,
  output logic [MEM_W-1:0]  rdata
);

  logic [MEM_W-1:0] mem_r [0:(1 << ADDR_W) - 1];

  // Array write port; no reset so it stays RAM-inferable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Output register with synchronous reset, updated only on reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/generable_mem_sweep.sv
// Single-port, byte-lane-enabled memory with a registered read port. After reset or
// a clr pulse a sweep FSM clears one address per cycle before requests are accepted.
module generable_mem_sweep
  import generable_mem_sweep_pkg::*;
#(
  parameter  int               ADDR_W  = 10,
  parameter  int               DATA_W  = 32,
  parameter  int               MEM_W   = 8,
  localparam int               N_MEM   = DATA_W / MEM_W,
  parameter  logic [MEM_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [N_MEM-1:0]  req_wstrb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  if (!lanes_ok(DATA_W, MEM_W)) begin : g_cfg_err
    $error("generable_mem_sweep: DATA_W must be a non-zero multiple of MEM_W");
  end

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_e              state_r, state_n_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_n_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [N_MEM-1:0]    lane_we_s;
  logic [N_MEM-1:0]    lane_we_g_s;
  logic                rd_en_s;
  logic                rd_en_g_s;
  logic                accept_s;
  logic                rsp_valid_r;

  assign accept_s  = req_valid && (state_r == IDLE);
  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r == SWEEP);
  assign rsp_valid = rsp_valid_r;

  // A reset cycle must never disturb the array or the read register.
  assign lane_we_g_s = rst ? {N_MEM{1'b0}} : lane_we_s;
  assign rd_en_g_s   = rst ? 1'b0 : rd_en_s;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SWEEP;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Next state plus the port mux between sweep writes and external requests.
  always_comb begin
    state_n_s   = state_r;
    cnt_n_s     = cnt_r;
    mem_addr_s  = req_addr;
    mem_wdata_s = req_wdata;
    lane_we_s   = {N_MEM{1'b0}};
    rd_en_s     = 1'b0;
    case (state_r)
      SWEEP: begin
        mem_addr_s  = cnt_r;
        mem_wdata_s = {N_MEM{CLR_VAL}};
        lane_we_s   = {N_MEM{1'b1}};
        if (cnt_r == CNT_LAST) begin
          state_n_s = IDLE;
          cnt_n_s   = '0;
        end else begin
          cnt_n_s = cnt_r + ADDR_W'(1'b1);
        end
      end
      IDLE: begin
        // A request accepted alongside clr still completes before the sweep.
        lane_we_s = accept_s ? req_wstrb : {N_MEM{1'b0}};
        rd_en_s   = accept_s && (req_wstrb == {N_MEM{1'b0}});
        if (clr) begin
          state_n_s = SWEEP;
          cnt_n_s   = '0;
        end else begin
          state_n_s = IDLE;
        end
      end
      default: begin
        state_n_s = SWEEP;
        cnt_n_s   = '0;
      end
    endcase
  end

  // Response strobe: one cycle after each accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rd_en_s;
    end
  end

  for (genvar i = 0; i < N_MEM; i++) begin : g_lane
    generable_mem_lane #(
      .ADDR_W (ADDR_W),
      .MEM_W  (MEM_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (lane_we_g_s[i]),
      .re    (rd_en_g_s),
      .addr  (mem_addr_s),
      .wdata (mem_wdata_s[lane_lsb(i, MEM_W) +: MEM_W]),
      .rdata (rsp_rdata[lane_lsb(i, MEM_W) +: MEM_W])
    );
  end

endmodule
